// File: rtl/dreg_shifter_pkg.sv
// Shared types for the dreg_shifter storage register.
package dreg_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5,
    ASR  = 3'd6,
    CLR  = 3'd7
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/dreg_shifter_shift_step.sv
// Single shift/rotate step: purely combinational next word and out-bit.
module shift_step
  import dreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt,
  output logic             out_bit
);

  // Select the one-position move for the requested shift/rotate kind
  always_comb begin
    q_nxt   = q;
    out_bit = 1'b0;
    case (mode)
      SHL: begin
        q_nxt   = {q[WIDTH-2:0], sin};
        out_bit = q[WIDTH-1];
      end
      SHR: begin
        q_nxt   = {sin, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      ROL: begin
        q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      ROR: begin
        q_nxt   = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      ASR: begin
        q_nxt   = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_nxt   = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dreg_shifter.sv
// Multi-mode storage register: load/clear/hold plus multi-cycle shifts and
// rotates with a busy/done handshake.
module dreg_shifter
  import dreg_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               AW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    amt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  mode_e            cmd_mode;
  mode_e            step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  assign cmd_mode = mode_e'(mode);

  // First step uses the live command; later steps use the latched mode
  always_comb begin
    step_mode = (state_q == SHIFT) ? mode_q : cmd_mode;
  end

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q      (q_q),
    .mode   (step_mode),
    .sin    (sin),
    .q_nxt  (step_q),
    .out_bit(step_out)
  );

  // Command acceptance and per-cycle step sequencing
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          mode_d = cmd_mode;
          done_d = 1'b1;
          case (cmd_mode)
            HOLD: q_d = q_q;
            LOAD: q_d = d;
            CLR:  q_d = RESET_VAL;
            default: begin
              // Step 1 happens on the accepting edge; counter holds the rest
              if (amt != '0) begin
                q_d    = step_q;
                sout_d = step_out;
                if (amt != AW'(1)) begin
                  done_d  = 1'b0;
                  cnt_d   = amt - AW'(1);
                  state_d = SHIFT;
                end
              end
            end
          endcase
        end
      end
      SHIFT: begin
        q_d    = step_q;
        sout_d = step_out;
        if (cnt_q == AW'(1)) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= HOLD;
      cnt_q   <= '0;
      q_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign q_n  = ~q_q;
  assign sout = sout_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_dreg_shifter.sv
// Self-checking bench for dreg_shifter (WIDTH=8).
module tb_dreg_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] amt;
  logic       sin;
  logic [7:0] q, q_n;
  logic       sout, busy, done;

  logic       en2;
  logic [2:0] mode2;
  logic [7:0] d2;
  logic [7:0] q2, q_n2;
  logic       sout2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int m_q    = 0;
  int m_sout = 0;

  always #5 clk = ~clk;

  dreg_shifter #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .amt(amt),
    .sin(sin), .q(q), .q_n(q_n), .sout(sout), .busy(busy), .done(done)
  );

  dreg_shifter #(.WIDTH(8), .RESET_VAL(8'h0F)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .mode(mode2), .d(d2), .amt(amt),
    .sin(sin), .q(q2), .q_n(q_n2), .sout(sout2), .busy(busy2), .done(done2)
  );

  // Reference: one step expressed as plain integer arithmetic on 0..255
  function automatic int ref_step_q(input int md, input int v, input int s);
    case (md)
      2:       return (v * 2 + s) % 256;
      3:       return v / 2 + s * 128;
      4:       return (v * 2) % 256 + v / 128;
      5:       return v / 2 + (v % 2) * 128;
      6:       return v / 2 + (v / 128) * 128;
      default: return v;
    endcase
  endfunction

  function automatic int ref_step_out(input int md, input int v);
    case (md)
      2, 4:    return v / 128;
      3, 5, 6: return v % 2;
      default: return 0;
    endcase
  endfunction

  // Issue one command at the next edge and follow it to completion
  task automatic run_cmd(input int md, input int dv, input int am, input int sfix, input bit junk);
    int steps;
    int s;
    logic [7:0] eq;
    steps = (md >= 2 && md <= 6) ? am : 0;
    en    = 1'b1;
    mode  = md[2:0];
    d     = dv[7:0];
    amt   = am[3:0];
    sin   = (sfix < 0) ? 1'($urandom) : sfix[0];
    if (steps == 0) begin
      if (md == 1) m_q = dv % 256;
      else if (md == 7) m_q = 0;
      @(posedge clk); #1;
      en = 1'b0;
      eq = m_q[7:0];
      checks += 5;
      if (q !== eq) begin errors++; $display("FAIL cmd_q mode=%0d q=%h exp=%h", md, q, eq); end
      if (q_n !== ~eq) begin errors++; $display("FAIL cmd_qn mode=%0d q_n=%h exp=%h", md, q_n, ~eq); end
      if (sout !== m_sout[0]) begin errors++; $display("FAIL cmd_sout mode=%0d sout=%b exp=%b", md, sout, m_sout[0]); end
      if (busy !== 1'b0) begin errors++; $display("FAIL cmd_busy mode=%0d busy=%b exp=0", md, busy); end
      if (done !== 1'b1) begin errors++; $display("FAIL cmd_done mode=%0d done=%b exp=1", md, done); end
    end else begin
      for (int k = 0; k < steps; k++) begin
        s      = int'(sin);
        m_sout = ref_step_out(md, m_q);
        m_q    = ref_step_q(md, m_q, s);
        @(posedge clk); #1;
        if (junk && k < steps - 1) begin
          en = 1'b1; mode = 3'd1; d = 8'hFF; amt = 4'($urandom);
        end else begin
          en = 1'b0;
        end
        sin = (sfix < 0) ? 1'($urandom) : sfix[0];
        eq  = m_q[7:0];
        checks += 4;
        if (q !== eq) begin errors++; $display("FAIL shift_q mode=%0d step=%0d q=%h exp=%h", md, k, q, eq); end
        if (q_n !== ~eq) begin errors++; $display("FAIL shift_qn mode=%0d step=%0d q_n=%h exp=%h", md, k, q_n, ~eq); end
        if (busy !== (k < steps - 1)) begin errors++; $display("FAIL shift_busy mode=%0d step=%0d busy=%b exp=%b", md, k, busy, (k < steps - 1)); end
        if (done !== (k == steps - 1)) begin errors++; $display("FAIL shift_done mode=%0d step=%0d done=%b exp=%b", md, k, done, (k == steps - 1)); end
        if (k == steps - 1) begin
          checks++;
          if (sout !== m_sout[0]) begin errors++; $display("FAIL shift_sout mode=%0d sout=%b exp=%b", md, sout, m_sout[0]); end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; en2 = 1'b0; mode = 3'd0; mode2 = 3'd0;
    d = '0; d2 = '0; amt = '0; sin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_q = 0; m_sout = 0;
    checks += 6;
    if (q !== 8'h00) begin errors++; $display("FAIL reset_q q=%h exp=00", q); end
    if (q_n !== 8'hFF) begin errors++; $display("FAIL reset_qn q_n=%h exp=ff", q_n); end
    if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout sout=%b exp=0", sout); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy busy=%b exp=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done done=%b exp=0", done); end
    if (q2 !== 8'h0F) begin errors++; $display("FAIL reset_q2 q=%h exp=0f", q2); end
  endtask

  task automatic test_load_and_idle();
    run_cmd(1, 'hA5, 0, 0, 1'b0);
    checks += 2;
    if (q !== 8'hA5) begin errors++; $display("FAIL load_a5 q=%h exp=a5", q); end
    if (q_n !== 8'h5A) begin errors++; $display("FAIL load_a5_qn q_n=%h exp=5a", q_n); end
    @(posedge clk); #1;
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("FAIL idle_done done=%b exp=0", done); end
    if (q !== 8'hA5) begin errors++; $display("FAIL idle_q q=%h exp=a5", q); end
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy busy=%b exp=0", busy); end
  endtask

  task automatic test_directed_shifts();
    run_cmd(2, 0, 3, 0, 1'b1);
    checks += 2;
    if (q !== 8'h28) begin errors++; $display("FAIL shl3 q=%h exp=28", q); end
    if (sout !== 1'b1) begin errors++; $display("FAIL shl3_sout sout=%b exp=1", sout); end
    run_cmd(1, 'hA5, 0, 0, 1'b0);
    run_cmd(5, 0, 4, -1, 1'b0);
    checks++;
    if (q !== 8'h5A) begin errors++; $display("FAIL ror4 q=%h exp=5a", q); end
    run_cmd(4, 0, 9, -1, 1'b1);
    checks++;
    if (q !== 8'hB4) begin errors++; $display("FAIL rol9 q=%h exp=b4", q); end
    run_cmd(1, 'h80, 0, 0, 1'b0);
    run_cmd(6, 0, 2, -1, 1'b0);
    checks++;
    if (q !== 8'hE0) begin errors++; $display("FAIL asr2 q=%h exp=e0", q); end
    run_cmd(3, 0, 8, 1, 1'b0);
    checks++;
    if (q !== 8'hFF) begin errors++; $display("FAIL shr8 q=%h exp=ff", q); end
    run_cmd(1, 'h3C, 0, 0, 1'b0);
    run_cmd(2, 0, 0, -1, 1'b0);
    checks++;
    if (q !== 8'h3C) begin errors++; $display("FAIL shl0 q=%h exp=3c", q); end
    run_cmd(5, 0, 1, -1, 1'b0);
    checks++;
    if (q !== 8'h1E) begin errors++; $display("FAIL ror1 q=%h exp=1e", q); end
    run_cmd(2, 0, 15, 1, 1'b0);
    checks++;
    if (q !== 8'hFF) begin errors++; $display("FAIL shl15_flush q=%h exp=ff", q); end
  endtask

  task automatic test_reset_mid_shift();
    run_cmd(1, 'hFF, 0, 0, 1'b0);
    en = 1'b1; mode = 3'd3; amt = 4'd5; sin = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre busy=%b exp=1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_q = 0; m_sout = 0;
    checks += 4;
    if (q !== 8'h00) begin errors++; $display("FAIL abort_q q=%h exp=00", q); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy busy=%b exp=0", busy); end
    if (sout !== 1'b0) begin errors++; $display("FAIL abort_sout sout=%b exp=0", sout); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done done=%b exp=0", done); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks += 2;
      if (done !== 1'b0) begin errors++; $display("FAIL abort_late_done cyc=%0d done=%b exp=0", i, done); end
      if (q !== 8'h00) begin errors++; $display("FAIL abort_late_q cyc=%0d q=%h exp=00", i, q); end
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(1, 'h5C, 0, 0, 1'b0);
    run_cmd(0, 'h11, 0, 0, 1'b0);
    run_cmd(7, 'h22, 0, 0, 1'b0);
    run_cmd(1, 'h96, 0, 0, 1'b0);
    run_cmd(2, 0, 3, -1, 1'b0);
    run_cmd(6, 0, 2, -1, 1'b0);
    run_cmd(1, 'h01, 0, 0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_tail_done done=%b exp=0", done); end
  endtask

  task automatic test_clr_resetval();
    en2 = 1'b1; mode2 = 3'd1; d2 = 8'h3C;
    @(posedge clk); #1;
    checks++;
    if (q2 !== 8'h3C) begin errors++; $display("FAIL rv_load q=%h exp=3c", q2); end
    mode2 = 3'd7;
    @(posedge clk); #1;
    en2 = 1'b0;
    checks += 3;
    if (q2 !== 8'h0F) begin errors++; $display("FAIL rv_clr q=%h exp=0f", q2); end
    if (q_n2 !== 8'hF0) begin errors++; $display("FAIL rv_clr_qn q_n=%h exp=f0", q_n2); end
    if (done2 !== 1'b1) begin errors++; $display("FAIL rv_clr_done done=%b exp=1", done2); end
    @(posedge clk); #1;
    checks++;
    if (done2 !== 1'b0) begin errors++; $display("FAIL rv_after_done done=%b exp=0", done2); end
  endtask

  task automatic test_random();
    int md;
    for (int i = 0; i < 40; i++) begin
      md = int'($urandom_range(7, 0));
      run_cmd(md, int'($urandom_range(255, 0)), int'($urandom_range(15, 0)), -1, 1'($urandom));
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL rand_gap_done iter=%0d done=%b exp=0", i, done); end
        if (q !== m_q[7:0]) begin errors++; $display("FAIL rand_gap_q iter=%0d q=%h exp=%h", i, q, m_q[7:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_and_idle();
    test_directed_shifts();
    test_reset_mid_shift();
    test_back_to_back();
    test_clr_resetval();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
